pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (F, D, X, M, W).
- Consumes the hazard unit's `bubble`, the X-stage branch resolution, data-memory handshake and halt signalling.
- Drives per-stage pipeline-register enables and NOP-insert strobes, the PC select, and saturating stall/flush counters.
- Sits beside the hazard detection unit in the top-level core.

Parameters:
- FLUSH_CYCLES, 1: extra cycles PC/FD held after a taken branch (branch penalty beyond the mandatory squash); range 0..7.
- CNT_W, 16: width of performance counters.

Ports:
- clk  in  1  core clock
- n_reset  in  1  asynchronous active-low reset
- bubble  in  1  load/store-use hazard from hazard unit (XM vs DX)
- branch_taken  in  1  branch in DX resolved taken this cycle
- dmem_req  in  1  XM stage holds a load/store
- dmem_ack  in  1  data memory completes the XM access this cycle
- halt_dx  in  1  halt instruction in DX
- restart  in  1  leave HALTED
- en_pc, en_fd, en_dx, en_xm, en_mw  out  1 each  pipeline register load enables
- nop_fd, nop_dx, nop_xm, nop_mw  out  1 each  load NOP (clears op_writes_rf/load/store flags) into that register when its enable is 1
- pc_sel  out  1  1 = PC loads branch target, 0 = PC+1
- halted  out  1  core halted
- stall_cnt  out  CNT_W  cycles with en_pc=0 caused by bubble or memory wait
- flush_cnt  out  CNT_W  taken branches squashed

Behaviour:
- Reset (n_reset low, async): state=START, counters=0, flush counter=0. All en_* = 0, nop_* = 1, pc_sel=0, halted=0.
- State register and counters update on rising clk. All other outputs are combinational from state and inputs.
- States: START, RUN, MEM_WAIT, FLUSH, HALTED.
- START (one cycle):
  - All en_* = 1, all nop_* = 1, pc_sel=0: pipeline filled with NOPs.
  - Next state: RUN.
- RUN default: all en_* = 1, nop_* = 0, pc_sel=0.
- RUN priority, highest first:
  1. dmem_req && !dmem_ack:
     - en_pc=en_fd=en_dx=en_xm=0; en_mw=1 with nop_mw=1.
     - Next state: MEM_WAIT; stall_cnt++.
  2. bubble:
     - en_pc=en_fd=en_dx=0; en_xm=en_mw=1, nop_xm=1.
     - Stay in RUN; stall_cnt++.
  3. branch_taken:
     - pc_sel=1, en_pc=1.
     - nop_fd=1, nop_dx=1 (squash the two younger instructions).
     - flush_cnt++.
     - Next state: FLUSH if FLUSH_CYCLES>0, loading the flush counter with FLUSH_CYCLES; else RUN.
  4. halt_dx:
     - Normal advance this cycle; en_pc=en_fd=0 (stop fetch).
     - Next state: HALTED.
- MEM_WAIT:
  - Same outputs as RUN item 1, held until dmem_ack=1; stall_cnt++ on every non-ack cycle.
  - On dmem_ack: RUN outputs for that cycle (all enables 1; branch/bubble evaluated as in RUN); next state RUN.
- FLUSH:
  - en_pc=en_fd=0; en_dx=1 with nop_dx=1; en_xm=en_mw=1.
  - Flush counter decrements; at 1, next state RUN.
  - dmem_req && !dmem_ack takes priority: behave as MEM_WAIT outputs without decrementing, and stay in FLUSH.
- HALTED:
  - halted=1; en_pc=en_fd=0, en_dx=1 with nop_dx=1; en_xm=en_mw=1 so in-flight instructions drain.
  - restart=1: next state RUN, halted drops the following cycle.
- Simultaneous events:
  - bubble + branch_taken: bubble wins. DX is held, so branch_taken re-presents next cycle.
  - Memory stall + anything: memory stall wins.
  - halt_dx + branch_taken: branch wins; the halt is squashed.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-MEM_WAIT/FLUSH/HALTED: immediate return to reset outputs; the pending access is abandoned.

Test Plan:
1. Reset release: n_reset low 3 cycles, then high → START cycle shows all en=1/nop=1; next cycle RUN with all en=1, nop=0; counters 0.
2. Load-use: bubble=1 for one cycle in RUN → that cycle en_pc/fd/dx=0, nop_xm=1; stall_cnt=1; next cycle all enables 1.
3. Memory wait: dmem_req=1, dmem_ack low 4 cycles then high → 4 cycles en_pc..en_xm=0 with nop_mw=1; stall_cnt=4; ack cycle all enables 1; then RUN.
4. Branch with FLUSH_CYCLES=2: branch_taken one cycle → pc_sel=1, nop_fd=nop_dx=1; then 2 FLUSH cycles with en_pc=0 and nop_dx=1; flush_cnt=1; RUN on third cycle.
5. Priority: bubble=1 and branch_taken=1 together → bubble outputs, pc_sel=0; next cycle bubble=0, branch_taken=1 → branch taken, flush_cnt=1.
6. Halt: halt_dx=1 → halted=1 next cycle, en_pc=0 for 5 cycles; restart=1 → RUN; assert n_reset low mid-HALTED → halted=0 and all en_*=0 immediately.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage F/D/X/M/W pipeline: register enables,
// NOP-insert strobes, PC select and saturating stall/flush counters.
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             bubble,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    input  logic             halt_dx,
    input  logic             restart,
    output logic             en_pc,
    output logic             en_fd,
    output logic             en_dx,
    output logic             en_xm,
    output logic             en_mw,
    output logic             nop_fd,
    output logic             nop_dx,
    output logic             nop_xm,
    output logic             nop_mw,
    output logic             pc_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [2:0] {S_START, S_RUN, S_MEM_WAIT, S_FLUSH, S_HALTED} state_t;

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

    state_t           r_state, w_next;
    logic [2:0]       r_fcnt, w_fcnt_next;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_stall_inc, w_flush_inc, w_run, w_mem_stall;
    logic [4:0]       w_en;   // {pc, fd, dx, xm, mw}
    logic [3:0]       w_nop;  // {fd, dx, xm, mw}
    logic             w_pc_sel, w_halted;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= S_START;
            r_fcnt      <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_fcnt  <= w_fcnt_next;
            if (w_stall_inc && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_inc && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_fcnt_next = r_fcnt;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        w_run       = 1'b0;
        w_mem_stall = 1'b0;
        w_en        = 5'b11111;
        w_nop       = 4'b0000;
        w_pc_sel    = 1'b0;
        w_halted    = 1'b0;

        case (r_state)
            S_START: begin
                w_nop  = 4'b1111;
                w_next = S_RUN;
            end
            S_RUN: w_run = 1'b1;
            S_MEM_WAIT: begin
                if (!dmem_ack) begin
                    w_mem_stall = 1'b1;
                end else begin
                    w_run  = 1'b1;
                    w_next = S_RUN;
                end
            end
            S_FLUSH: begin
                // A memory stall freezes the flush countdown in place.
                if (dmem_req && !dmem_ack) begin
                    w_mem_stall = 1'b1;
                end else begin
                    w_en        = 5'b00111;
                    w_nop       = 4'b0100;
                    w_fcnt_next = r_fcnt - 3'd1;
                    if (r_fcnt <= 3'd1) w_next = S_RUN;
                end
            end
            S_HALTED: begin
                w_halted = 1'b1;
                w_en     = 5'b00111;
                w_nop    = 4'b0100;
                if (restart) w_next = S_RUN;
            end
            default: w_next = S_START;
        endcase

        if (w_run) begin
            if (dmem_req && !dmem_ack) begin
                w_mem_stall = 1'b1;
                w_next      = S_MEM_WAIT;
            end else if (bubble) begin
                // DX held, so a coincident branch re-presents next cycle.
                w_en        = 5'b00011;
                w_nop       = 4'b0010;
                w_stall_inc = 1'b1;
            end else if (branch_taken) begin
                w_pc_sel    = 1'b1;
                w_nop       = 4'b1100;
                w_flush_inc = 1'b1;
                if (FLUSH_CYCLES > 0) begin
                    w_next      = S_FLUSH;
                    w_fcnt_next = FLUSH_LD;
                end
            end else if (halt_dx) begin
                w_en   = 5'b00111;
                w_next = S_HALTED;
            end
        end

        if (w_mem_stall) begin
            w_en        = 5'b00001;
            w_nop       = 4'b0001;
            w_stall_inc = 1'b1;
        end
    end

    // Reset overrides the state-derived outputs while n_reset is low.
    assign en_pc     = n_reset & w_en[4];
    assign en_fd     = n_reset & w_en[3];
    assign en_dx     = n_reset & w_en[2];
    assign en_xm     = n_reset & w_en[1];
    assign en_mw     = n_reset & w_en[0];
    assign nop_fd    = ~n_reset | w_nop[3];
    assign nop_dx    = ~n_reset | w_nop[2];
    assign nop_xm    = ~n_reset | w_nop[1];
    assign nop_mw    = ~n_reset | w_nop[0];
    assign pc_sel    = n_reset & w_pc_sel;
    assign halted    = n_reset & w_halted;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: main DUT with FLUSH_CYCLES=2, plus a
// FLUSH_CYCLES=0 / 3-bit-counter instance for the no-flush and saturation cases.
module tb_pipeline_ctrl;

    // {en_pc,en_fd,en_dx,en_xm,en_mw, nop_fd,nop_dx,nop_xm,nop_mw, pc_sel, halted}
    localparam logic [10:0] C_RESET  = 11'b00000_1111_0_0;
    localparam logic [10:0] C_START  = 11'b11111_1111_0_0;
    localparam logic [10:0] C_RUN    = 11'b11111_0000_0_0;
    localparam logic [10:0] C_MEM    = 11'b00001_0001_0_0;
    localparam logic [10:0] C_BUBBLE = 11'b00011_0010_0_0;
    localparam logic [10:0] C_BRANCH = 11'b11111_1100_1_0;
    localparam logic [10:0] C_FLUSH  = 11'b00111_0100_0_0;
    localparam logic [10:0] C_HALTGO = 11'b00111_0000_0_0;
    localparam logic [10:0] C_HALTED = 11'b00111_0100_0_1;

    logic clk = 1'b0;
    logic n_reset, bubble, branch_taken, dmem_req, dmem_ack, halt_dx, restart;
    logic en_pc, en_fd, en_dx, en_xm, en_mw, nop_fd, nop_dx, nop_xm, nop_mw, pc_sel, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic en_pc2, en_fd2, en_dx2, en_xm2, en_mw2, nop_fd2, nop_dx2, nop_xm2, nop_mw2, pc_sel2, halted2;
    logic [2:0] stall_cnt2, flush_cnt2;
    logic [10:0] ctl, ctl2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign ctl  = {en_pc, en_fd, en_dx, en_xm, en_mw, nop_fd, nop_dx, nop_xm, nop_mw, pc_sel, halted};
    assign ctl2 = {en_pc2, en_fd2, en_dx2, en_xm2, en_mw2, nop_fd2, nop_dx2, nop_xm2, nop_mw2, pc_sel2, halted2};

    pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
        .clk(clk), .n_reset(n_reset), .bubble(bubble), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .halt_dx(halt_dx), .restart(restart),
        .en_pc(en_pc), .en_fd(en_fd), .en_dx(en_dx), .en_xm(en_xm), .en_mw(en_mw),
        .nop_fd(nop_fd), .nop_dx(nop_dx), .nop_xm(nop_xm), .nop_mw(nop_mw),
        .pc_sel(pc_sel), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.FLUSH_CYCLES(0), .CNT_W(3)) u_dut0 (
        .clk(clk), .n_reset(n_reset), .bubble(bubble), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .halt_dx(halt_dx), .restart(restart),
        .en_pc(en_pc2), .en_fd(en_fd2), .en_dx(en_dx2), .en_xm(en_xm2), .en_mw(en_mw2),
        .nop_fd(nop_fd2), .nop_dx(nop_dx2), .nop_xm(nop_xm2), .nop_mw(nop_mw2),
        .pc_sel(pc_sel2), .halted(halted2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset, release, and step through START so the DUT sits in RUN.
    task automatic do_reset;
        n_reset = 1'b0; bubble = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0;
        dmem_ack = 1'b0; halt_dx = 1'b0; restart = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        n_reset = 1'b0; bubble = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0;
        dmem_ack = 1'b0; halt_dx = 1'b0; restart = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++; if (ctl !== C_RESET) begin n_fail++; $display("FAIL reset_ctl got %b expected %b", ctl, C_RESET); end
        n_checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        n_checks++; if (ctl2 !== C_RESET) begin n_fail++; $display("FAIL reset_ctl_dut0 got %b expected %b", ctl2, C_RESET); end
        n_reset = 1'b1;
        #1;
        n_checks++; if (ctl !== C_START) begin n_fail++; $display("FAIL start_ctl got %b expected %b", ctl, C_START); end
        tick();
        #2;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL run_after_start got %b expected %b", ctl, C_RUN); end
        n_checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_after_start got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_load_use;
        do_reset();
        bubble = 1'b1; #2;
        n_checks++; if (ctl !== C_BUBBLE) begin n_fail++; $display("FAIL bubble_ctl got %b expected %b", ctl, C_BUBBLE); end
        tick();
        bubble = 1'b0; #2;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL bubble_resume got %b expected %b", ctl, C_RUN); end
        n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL bubble_stall_cnt got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_mem_wait;
        do_reset();
        dmem_req = 1'b1; dmem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_checks++; if (ctl !== C_MEM) begin n_fail++; $display("FAIL mem_wait_ctl[%0d] got %b expected %b", i, ctl, C_MEM); end
            tick();
        end
        dmem_ack = 1'b1; #2;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL mem_ack_ctl got %b expected %b", ctl, C_RUN); end
        n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL mem_stall_cnt got %0d expected 4", stall_cnt); end
        tick();
        dmem_req = 1'b0; dmem_ack = 1'b0; #2;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL mem_after_ack got %b expected %b", ctl, C_RUN); end
        n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL mem_stall_cnt_hold got %0d expected 4", stall_cnt); end
    endtask

    task automatic test_branch;
        do_reset();
        branch_taken = 1'b1; #2;
        n_checks++; if (ctl !== C_BRANCH) begin n_fail++; $display("FAIL branch_ctl got %b expected %b", ctl, C_BRANCH); end
        tick();
        branch_taken = 1'b0; #2;
        n_checks++; if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL flush1_ctl got %b expected %b", ctl, C_FLUSH); end
        n_checks++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL branch_flush_cnt got %0d expected 1", flush_cnt); end
        n_checks++; if (ctl2 !== C_RUN) begin n_fail++; $display("FAIL noflush_dut0_ctl got %b expected %b", ctl2, C_RUN); end
        n_checks++; if (flush_cnt2 !== 3'd1) begin n_fail++; $display("FAIL noflush_dut0_cnt got %0d expected 1", flush_cnt2); end
        tick(); #2;
        n_checks++; if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL flush2_ctl got %b expected %b", ctl, C_FLUSH); end
        tick(); #2;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL flush_done_ctl got %b expected %b", ctl, C_RUN); end
    endtask

    task automatic test_priority;
        do_reset();
        bubble = 1'b1; branch_taken = 1'b1; #2;
        n_checks++; if (ctl !== C_BUBBLE) begin n_fail++; $display("FAIL bub_br_ctl got %b expected %b", ctl, C_BUBBLE); end
        tick();
        bubble = 1'b0; #2;
        n_checks++; if (ctl !== C_BRANCH) begin n_fail++; $display("FAIL br_repres_ctl got %b expected %b", ctl, C_BRANCH); end
        n_checks++; if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL br_repres_cnt got %0d expected 0", flush_cnt); end
        tick();
        branch_taken = 1'b0; #2;
        n_checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin n_fail++; $display("FAIL prio_cnts got %0d/%0d expected 1/1", flush_cnt, stall_cnt); end
        // Memory stall in the first FLUSH cycle freezes the countdown.
        dmem_req = 1'b1; bubble = 1'b1; #2;
        n_checks++; if (ctl !== C_MEM) begin n_fail++; $display("FAIL flush_mem_ctl got %b expected %b", ctl, C_MEM); end
        tick();
        dmem_req = 1'b0; bubble = 1'b0; #2;
        n_checks++; if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL flush_mem_resume got %b expected %b", ctl, C_FLUSH); end
        n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL flush_mem_stall_cnt got %0d expected 2", stall_cnt); end
        tick(); #2;
        n_checks++; if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL flush_mem_last got %b expected %b", ctl, C_FLUSH); end
        tick(); #2;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL flush_mem_done got %b expected %b", ctl, C_RUN); end
        // Halt and branch together: the branch wins, no halt.
        halt_dx = 1'b1; branch_taken = 1'b1; #2;
        n_checks++; if (ctl !== C_BRANCH) begin n_fail++; $display("FAIL halt_br_ctl got %b expected %b", ctl, C_BRANCH); end
        tick();
        halt_dx = 1'b0; branch_taken = 1'b0; #2;
        n_checks++; if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL halt_br_next got %b expected %b", ctl, C_FLUSH); end
    endtask

    task automatic test_halt;
        do_reset();
        halt_dx = 1'b1; #2;
        n_checks++; if (ctl !== C_HALTGO) begin n_fail++; $display("FAIL halt_issue_ctl got %b expected %b", ctl, C_HALTGO); end
        tick();
        halt_dx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_checks++; if (ctl !== C_HALTED) begin n_fail++; $display("FAIL halted_ctl[%0d] got %b expected %b", i, ctl, C_HALTED); end
            tick();
        end
        restart = 1'b1; #2;
        n_checks++; if (ctl !== C_HALTED) begin n_fail++; $display("FAIL restart_cycle_ctl got %b expected %b", ctl, C_HALTED); end
        tick();
        restart = 1'b0; #2;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL restart_run_ctl got %b expected %b", ctl, C_RUN); end
        halt_dx = 1'b1;
        tick();
        halt_dx = 1'b0; #2;
        n_checks++; if (ctl !== C_HALTED) begin n_fail++; $display("FAIL rehalt_ctl got %b expected %b", ctl, C_HALTED); end
        n_reset = 1'b0; #1;
        n_checks++; if (ctl !== C_RESET) begin n_fail++; $display("FAIL reset_mid_halt got %b expected %b", ctl, C_RESET); end
        n_reset = 1'b1;
    endtask

    task automatic test_saturate;
        do_reset();
        bubble = 1'b1;
        repeat (10) tick();
        bubble = 1'b0; #2;
        n_checks++; if (stall_cnt2 !== 3'd7) begin n_fail++; $display("FAIL stall_sat_dut0 got %0d expected 7", stall_cnt2); end
        n_checks++; if (stall_cnt !== 16'd10) begin n_fail++; $display("FAIL stall_10 got %0d expected 10", stall_cnt); end
        // Main DUT takes a branch every third cycle (FLUSH x2 in between).
        branch_taken = 1'b1;
        repeat (9) tick();
        branch_taken = 1'b0; #2;
        n_checks++; if (flush_cnt2 !== 3'd7) begin n_fail++; $display("FAIL flush_sat_dut0 got %0d expected 7", flush_cnt2); end
        n_checks++; if (flush_cnt !== 16'd3) begin n_fail++; $display("FAIL flush_every3 got %0d expected 3", flush_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_priority();
        test_halt();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
